lcd_char_reader: RTL and testbench



---
 rtl/lcd_char_reader.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_char_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_reader.sv
// HD44780 4-bit read-back engine: sets the DDRAM address, polls BF,
// then reads one character code as two nibbles.
module lcd_char_reader #(
    parameter int T_SETUP  = 2,
    parameter int T_EHIGH  = 12,
    parameter int T_ELOW   = 12,
    parameter int BF_POLLS = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_err,
    output logic       busy,
    input  logic [3:0] lcd_din,
    output logic [3:0] dataout,
    output logic       data_oe,
    output logic [2:0] control
);

    localparam int TMAX = (T_SETUP > T_EHIGH)
                        ? ((T_SETUP > T_ELOW) ? T_SETUP : T_ELOW)
                        : ((T_EHIGH > T_ELOW) ? T_EHIGH : T_ELOW);
    localparam int CW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW = (BF_POLLS > 1) ? $clog2(BF_POLLS) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EHIGH_LAST = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] ELOW_LAST  = CW'(T_ELOW - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(BF_POLLS - 1);

    typedef enum logic [2:0] {
        IDLE, CMD_HI, CMD_LO, BF_HI, BF_LO, DAT_HI, DAT_LO, DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_EHIGH, PH_ELOW
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] polls_q, polls_d;
    logic [4:0]    addr_q, addr_d;
    logic          bf_q, bf_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q, rd_err_d;
    logic          busy_q, busy_d;

    logic [7:0] cmd;
    logic       in_nib;
    logic       sample;
    logic       nib_end;
    logic       e, rs, rw, oe;
    logic [3:0] dout;

    assign cmd     = {1'b1, addr_q[4], 2'b00, addr_q[3:0]};
    assign in_nib  = (state_q != IDLE) && (state_q != DONE);
    assign sample  = in_nib && (phase_q == PH_EHIGH)
                   && (cnt_q == EHIGH_LAST);
    assign nib_end = in_nib && (phase_q == PH_ELOW)
                   && (cnt_q == ELOW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            polls_q    <= '0;
            addr_q     <= '0;
            bf_q       <= 1'b0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            polls_q    <= polls_d;
            addr_q     <= addr_d;
            bf_q       <= bf_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        polls_d    = polls_q;
        addr_d     = addr_q;
        bf_d       = bf_q;
        shadow_d   = shadow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        busy_d     = busy_q & ~(rd_valid_q | rd_err_q);

        if (in_nib) begin
            cnt_d = cnt_q + 1'b1;
            unique case (phase_q)
                PH_SETUP: if (cnt_q == SETUP_LAST) begin
                    phase_d = PH_EHIGH;
                    cnt_d   = '0;
                end
                PH_EHIGH: if (cnt_q == EHIGH_LAST) begin
                    phase_d = PH_ELOW;
                    cnt_d   = '0;
                end
                PH_ELOW: if (cnt_q == ELOW_LAST) begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
                default: begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
            endcase
        end

        unique case (state_q)
            IDLE: if (rd_req && !busy_q) begin
                if (rd_addr[5]) begin
                    rd_err_d = 1'b1;
                end else begin
                    addr_d  = rd_addr[4:0];
                    busy_d  = 1'b1;
                    polls_d = '0;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    state_d = CMD_HI;
                end
            end
            CMD_HI: if (nib_end) state_d = CMD_LO;
            CMD_LO: if (nib_end) state_d = BF_HI;
            BF_HI: begin
                if (sample) bf_d = lcd_din[3];
                if (nib_end) state_d = BF_LO;
            end
            BF_LO: if (nib_end) begin
                if (!bf_q) begin
                    state_d = DAT_HI;
                end else if (polls_q == POLL_LAST) begin
                    rd_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    polls_d = polls_q + 1'b1;
                    state_d = BF_HI;
                end
            end
            DAT_HI: begin
                if (sample) shadow_d[7:4] = lcd_din;
                if (nib_end) state_d = DAT_LO;
            end
            DAT_LO: begin
                if (sample) shadow_d[3:0] = lcd_din;
                if (nib_end) state_d = DONE;
            end
            DONE: begin
                rd_data_d  = shadow_q;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus drive is a pure decode of registered state, so reset drops E at once.
    always_comb begin
        rs   = 1'b0;
        rw   = 1'b0;
        oe   = 1'b0;
        dout = 4'h0;
        unique case (state_q)
            CMD_HI: begin
                oe   = 1'b1;
                dout = cmd[7:4];
            end
            CMD_LO: begin
                oe   = 1'b1;
                dout = cmd[3:0];
            end
            BF_HI, BF_LO: rw = 1'b1;
            DAT_HI, DAT_LO: begin
                rs = 1'b1;
                rw = 1'b1;
            end
            default: ;
        endcase
        e = in_nib && (phase_q == PH_EHIGH);
    end

    assign control  = {e, rs, rw};
    assign dataout  = dout;
    assign data_oe  = oe;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_char_reader.sv
// Bench for lcd_char_reader: HD44780 bus model, vector table,
// hand-written corner sequences and randomized reads.
module tb_lcd_char_reader;

    localparam int POLLS = 4;
    localparam int NIB   = 26;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] val;
        int         bfn;
        logic       err;
        logic [7:0] data;
        int         lat;
        logic [7:0] cmd;
        int         pairs;
        logic       dat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_req = 1'b0;
    logic [5:0] rd_addr = 6'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_err;
    logic       busy;
    logic [3:0] lcd_din;
    logic [3:0] dataout;
    logic       data_oe;
    logic [2:0] control;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_char_reader #(.BF_POLLS(POLLS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_err(rd_err),
        .busy(busy),
        .lcd_din(lcd_din),
        .dataout(dataout),
        .data_oe(data_oe),
        .control(control)
    );

    // LCD model: DDRAM, address counter, BF busy for bf_cfg reads after a command
    logic [7:0] mem [128];
    int         bf_cfg = 0;
    logic       nib_hi = 1'b1;
    logic [3:0] cmd_hi = 4'h0;
    logic [6:0] ac = 7'h00;
    int         bf_reads = 0;
    logic       e_prev = 1'b0;
    logic [6:0] prev_bus = 7'h00;
    logic [6:0] log_mem [4096];
    int         log_n = 0;
    int         viol = 0;
    logic       e;
    logic [6:0] bus;
    logic [7:0] rd_byte;

    assign e   = control[2];
    assign bus = {control[1], control[0], data_oe, dataout};

    always_comb begin
        rd_byte = control[1] ? mem[ac] : {(bf_reads < bf_cfg), ac};
        lcd_din = 4'h0;
        if (control[0]) lcd_din = nib_hi ? rd_byte[7:4] : rd_byte[3:0];
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_hi <= 1'b1;
            e_prev <= 1'b0;
        end else begin
            e_prev   <= e;
            prev_bus <= bus;
            if (!e_prev && e) begin
                log_mem[log_n] <= bus;
                log_n <= log_n + 1;
            end
            if (e_prev && e && bus != prev_bus) viol <= viol + 1;
            if (e_prev && !e) begin
                nib_hi <= !nib_hi;
                if (!control[0]) begin
                    if (nib_hi) begin
                        cmd_hi <= dataout;
                    end else if (cmd_hi[3]) begin
                        ac <= {cmd_hi[2:0], dataout};
                        bf_reads <= 0;
                    end
                end else if (!nib_hi) begin
                    if (control[1]) ac <= ac + 7'd1;
                    else bf_reads <= bf_reads + 1;
                end
            end
        end
    end

    function automatic logic [6:0] ref_dd(input logic [5:0] a);
        return a[4] ? (7'h40 + {3'b000, a[3:0]}) : {3'b000, a[3:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input int start,
                             input logic [7:0] cmd, input int pairs,
                             input logic dat);
        logic [6:0] exp_q [$];
        logic [6:0] g;
        int bad;
        bad = 0;
        if (pairs > 0) begin
            exp_q.push_back({3'b001, cmd[7:4]});
            exp_q.push_back({3'b001, cmd[3:0]});
            for (int p = 0; p < 2 * pairs; p++) exp_q.push_back(7'b0100000);
            if (dat) begin
                exp_q.push_back(7'b1100000);
                exp_q.push_back(7'b1100000);
            end
        end
        chk({name, " nibble count"}, log_n - start, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_n - start; i++) begin
            g = log_mem[start + i];
            if (!g[4]) g[3:0] = 4'h0;
            if (g !== exp_q[i]) begin
                bad++;
                $display("  %s entry %0d: got %h want %h", name, i, g, exp_q[i]);
            end
        end
        chk({name, " bus sequence"}, bad, 0);
    endtask

    task automatic do_read(input logic [5:0] addr, input int bfn,
                           output logic [7:0] data, output int lat,
                           output logic err, output int st,
                           output logic held, output logic b_at,
                           output logic b_after, output logic one_pulse);
        logic [7:0] d0;
        int t0;
        logic got;
        data = '0; lat = -1; err = 1'b0; held = 1'b1;
        b_at = 1'b0; b_after = 1'b1; one_pulse = 1'b0; got = 1'b0;
        bf_cfg = bfn;
        d0 = rd_data;
        @(posedge clk); #1;
        st = log_n; rd_req = 1'b1; rd_addr = addr; t0 = cyc;
        @(posedge clk); #1;
        rd_req = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (rd_valid || rd_err) begin
                got = 1'b1;
                lat = cyc - t0;
                data = rd_data;
                err = rd_err;
                b_at = busy;
            end else if (rd_data !== d0) begin
                held = 1'b0;
            end
        end
        if (!got) chk("response timeout", 0, 1);
        @(negedge clk);
        b_after = busy;
        one_pulse = !rd_valid && !rd_err;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [7:0] d;
        int lat, st;
        logic err, held, b_at, b_after, one;
        if (!v.addr[5]) mem[ref_dd(v.addr)] = v.val;
        do_read(v.addr, v.bfn, d, lat, err, st, held, b_at, b_after, one);
        chk({name, " err"}, err, v.err);
        chk({name, " rd_data"}, d, v.data);
        chk({name, " latency"}, lat, v.lat);
        chk({name, " rd_data held"}, held, 1);
        chk({name, " busy at end"}, b_at, (v.pairs > 0));
        chk({name, " busy after"}, b_after, 0);
        chk({name, " single pulse"}, one, 1);
        repeat (30) @(negedge clk);
        check_log(name, st, v.cmd, v.pairs, v.dat);
    endtask

    vec_t vecs [8];

    initial begin
        vec_t v;
        int st, nv, ne, vk;

        vecs[0] = '{6'h03, 8'h49, 0,   1'b0, 8'h49, 158, 8'h83, 1, 1'b1};
        vecs[1] = '{6'h12, 8'h50, 0,   1'b0, 8'h50, 158, 8'hC2, 1, 1'b1};
        vecs[2] = '{6'h1F, 8'hA5, 3,   1'b0, 8'hA5, 314, 8'hCF, 4, 1'b1};
        vecs[3] = '{6'h00, 8'h3C, 1,   1'b0, 8'h3C, 210, 8'h80, 2, 1'b1};
        vecs[4] = '{6'h0A, 8'hE7, 255, 1'b1, 8'h3C, 261, 8'h8A, 4, 1'b0};
        vecs[5] = '{6'h20, 8'h00, 0,   1'b1, 8'h3C, 1,   8'h00, 0, 1'b0};
        vecs[6] = '{6'h35, 8'h00, 0,   1'b1, 8'h3C, 1,   8'h00, 0, 1'b0};
        vecs[7] = '{6'h10, 8'hC3, 2,   1'b0, 8'hC3, 262, 8'hC0, 3, 1'b1};

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk); #1;
        chk("reset rd_data", rd_data, 8'h00);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_err", rd_err, 0);
        chk("reset busy", busy, 0);
        chk("reset control", control, 3'b000);
        chk("reset data_oe", data_oe, 0);
        chk("reset dataout", dataout, 4'h0);
        rst_n = 1'b1;

        // Reset while E is high in the first command nibble
        bf_cfg = 0;
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = 6'h03;
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre-reset control", control, 3'b100);
        chk("pre-reset data_oe", data_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset control", control, 3'b000);
        chk("async reset data_oe", data_oe, 0);
        chk("async reset busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Requests during a transaction, including DONE and rd_valid cycles
        bf_cfg = 0;
        mem[ref_dd(6'h05)] = 8'h77;
        st = log_n; nv = 0; ne = 0; vk = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            rd_req = (k == 0 || k == 10 || k == 100 || k == 157 || k == 158);
            rd_addr = (k == 10) ? 6'h21 : ((k == 0) ? 6'h05 : 6'h06);
            @(negedge clk);
            if (rd_valid) begin
                nv++;
                vk = k;
            end
            if (rd_err) ne++;
        end
        rd_req = 1'b0;
        chk("ignore rd_valid count", nv, 1);
        chk("ignore rd_err count", ne, 0);
        chk("ignore latency", vk, 158);
        chk("ignore rd_data", rd_data, 8'h77);
        check_log("ignore", st, 8'h85, 1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            v.addr  = {1'b0, 5'($urandom)};
            v.val   = 8'($urandom);
            v.bfn   = $urandom_range(0, POLLS - 1);
            v.err   = 1'b0;
            v.data  = v.val;
            v.pairs = v.bfn + 1;
            v.lat   = (4 + 2 * v.pairs) * NIB + 2;
            v.cmd   = {1'b1, ref_dd(v.addr)};
            v.dat   = 1'b1;
            run_vec($sformatf("rnd%0d", n), v);
        end

        chk("bus stable while E high", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
